framebuffer_draw_engine: RTL and testbench
==========================================

Name: framebuffer_draw_engine

Overview:
Parametrised drawing engine that owns the single framebuffer RAM port, arbitrating between display scan-out and drawing writes.
- Accepts drawing commands over a valid/ready handshake: single pixel, square brush, full-screen clear, nop.
- Converts each command to a raster of pixel writes, issued only while the display does not own the port.
- Performs an automatic clear after reset.
- Sits between cursor/input logic, the pixel-display timing block and the framebuffer RAM.

Parameters:
- WIDTH, 160, framebuffer width in pixels
- HEIGHT, 120, framebuffer height in pixels
- ADDR_W, 15, framebuffer address width (must satisfy 2^ADDR_W >= WIDTH*HEIGHT)
- COLOUR_W, 12, pixel colour width
- MAX_BRUSH, 4, largest brush side length in pixels
- CLEAR_COLOUR, 12'hFFF, colour written by the post-reset clear

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_op  in  2  00 plot, 01 brush, 10 clear, 11 nop
- cmd_x  in  $clog2(WIDTH)  anchor column
- cmd_y  in  $clog2(HEIGHT)  anchor row
- cmd_size  in  $clog2(MAX_BRUSH+1)  brush side length
- cmd_colour  in  COLOUR_W  write colour
- screen_on  in  1  display owns the RAM port this cycle
- disp_addr  in  ADDR_W  display read address
- fb_addr  out  ADDR_W  RAM address
- fb_we  out  1  RAM write enable
- fb_wd  out  COLOUR_W  RAM write data
- busy  out  1  command or clear in progress
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset asserted (low):
  - State forced to CLEAR, counters zeroed.
  - fb_we=0, cmd_ready=0, busy=1, done=0, fb_wd=CLEAR_COLOUR.
  - A reset mid-command aborts it; the clear restarts from address 0 after reset deasserts.
- Pixel address = y*WIDTH + x, computed at ADDR_W width, unsigned, with no wrap.
- Port mux:
  - screen_on=1: fb_addr=disp_addr, fb_we=0, engine stalls holding its current x/y.
  - screen_on=0: fb_addr=engine address, fb_we=1 only in DRAW/CLEAR on an unclipped pixel.
- States:
  - CLEAR: writes addresses 0..WIDTH*HEIGHT-1 ascending, one per unstalled cycle, with the clear colour. After the last write it goes to DONE.
  - IDLE: cmd_ready=1, busy=0. A handshake (cmd_valid & cmd_ready) latches all cmd_* fields.
    - plot or brush: go to DRAW.
    - clear: go to CLEAR using the latched cmd_colour.
    - nop: go to DONE.
  - DRAW: iterates a square of side s, anchored top-left at (cmd_x, cmd_y), row-major with x inner.
    - plot: s=1.
    - brush: s=cmd_size, with cmd_size=0 treated as 1 and cmd_size>MAX_BRUSH clamped to MAX_BRUSH.
    - One pixel per unstalled cycle.
    - Pixels with x>=WIDTH or y>=HEIGHT are clipped: the cycle is consumed with fb_we=0 and no address is produced.
    - After the last pixel, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=1. Next cycle go to IDLE.
- cmd_ready=1 only in IDLE. cmd_valid held during any other state is ignored and is accepted on the first IDLE cycle.
- Latency with no stall:
  - First write occurs the cycle after acceptance.
  - Brush completes in s*s cycles plus 1 DONE cycle.
  - Clear completes in WIDTH*HEIGHT cycles plus 1.
  - Stall cycles add 1:1.
- fb_wd equals the latched colour whenever fb_we=1. Its value is don't-care otherwise.
- screen_on toggling on the final pixel: that pixel is written on the next unstalled cycle before DONE. A pixel is never skipped or written twice.

Test Plan:
- Release reset with screen_on=0 -> exactly 19200 writes of 12'hFFF to addresses 0..19199 in order, then one done pulse, then cmd_ready=1.
- Plot op=00, (5,3), colour 12'h0F0 -> one write, addr 485, data 12'h0F0; done pulses the next cycle.
- Brush op=01, size 3 at (158,118) -> writes only to 19038, 19039, 19198, 19199; 9 draw cycles plus 1 done cycle.
- Brush size 2 at (10,10) with screen_on=1 for 5 cycles after the first write -> during the stall fb_we=0 and fb_addr=disp_addr; writes resume at 1611; total addresses written 1610, 1611, 1770, 1771.
- cmd_valid held during a brush -> the second command is not accepted until the IDLE cycle after done. Brush size 0 -> single write. Size 7 -> 16 writes.
- Reset asserted mid-brush -> fb_we drops immediately; after deassertion a full clear restarts at address 0.

Source files
------------

// File: rtl/framebuffer_draw_engine.sv
// framebuffer_draw_engine: arbitrates the framebuffer RAM port between display scan-out and raster drawing commands
//   ports: clk, reset (async active-low); cmd_valid/cmd_ready/cmd_op/cmd_x/cmd_y/cmd_size/cmd_colour command handshake;
//          screen_on/disp_addr display side; fb_addr/fb_we/fb_wd RAM port; busy/done status
module framebuffer_draw_engine #(
  parameter int WIDTH = 160,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 15,
  parameter int COLOUR_W = 12,
  parameter int MAX_BRUSH = 4,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = COLOUR_W'('hFFF)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [$clog2(WIDTH)-1:0]       cmd_x,
  input  logic [$clog2(HEIGHT)-1:0]      cmd_y,
  input  logic [$clog2(MAX_BRUSH+1)-1:0] cmd_size,
  input  logic [COLOUR_W-1:0]            cmd_colour,
  input  logic                           screen_on,
  input  logic [ADDR_W-1:0]              disp_addr,
  output logic [ADDR_W-1:0]              fb_addr,
  output logic                           fb_we,
  output logic [COLOUR_W-1:0]            fb_wd,
  output logic                           busy,
  output logic                           done
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int SW = $clog2(MAX_BRUSH+1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH*HEIGHT-1);
  localparam logic [SW-1:0] ONE = SW'(1);
  localparam logic [SW-1:0] MAXS = SW'(MAX_BRUSH);
  typedef enum logic [1:0] {CLEAR, IDLE, DRAW, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [SW-1:0] dx_q, dx_d, dy_q, dy_d, side_q, side_d, size_c;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic [XW:0] px;
  logic [YW:0] py;
  logic clip, go;
  logic [ADDR_W-1:0] draw_addr;
  always_comb begin
    // one extra bit so pixels past the right/bottom edge are seen as clipped, not wrapped
    px = {1'b0, x_q} + (XW+1)'(dx_q);
    py = {1'b0, y_q} + (YW+1)'(dy_q);
    clip = (px >= (XW+1)'(WIDTH)) || (py >= (YW+1)'(HEIGHT));
    draw_addr = ADDR_W'(py) * ADDR_W'(WIDTH) + ADDR_W'(px);
    size_c = (cmd_size == '0) ? ONE : (cmd_size > MAXS) ? MAXS : cmd_size;
    go = !screen_on;
    state_d = state_q;
    clr_d = clr_q;
    dx_d = dx_q;
    dy_d = dy_q;
    side_d = side_q;
    x_d = x_q;
    y_d = y_q;
    colour_d = colour_q;
    case (state_q)
      CLEAR: if (go) begin
        clr_d = (clr_q == LAST) ? '0 : clr_q + ADDR_W'(1);
        state_d = (clr_q == LAST) ? DONE : CLEAR;
      end
      IDLE: if (cmd_valid) begin
        x_d = cmd_x;
        y_d = cmd_y;
        colour_d = cmd_colour;
        side_d = cmd_op[0] ? size_c : ONE;
        dx_d = '0;
        dy_d = '0;
        state_d = cmd_op[1] ? (cmd_op[0] ? DONE : CLEAR) : DRAW;
      end
      DRAW: if (go) begin
        dx_d = (dx_q == side_q - ONE) ? '0 : dx_q + ONE;
        dy_d = (dx_q == side_q - ONE) ? dy_q + ONE : dy_q;
        state_d = (dx_q == side_q - ONE && dy_q == side_q - ONE) ? DONE : DRAW;
      end
      DONE: state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      clr_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      side_q <= '0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= CLEAR_COLOUR;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      side_q <= side_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
    end
  end
  // reset gates the write enable combinationally so an aborted command stops writing at once
  assign fb_we = reset && go && (state_q == CLEAR || (state_q == DRAW && !clip));
  assign fb_addr = screen_on ? disp_addr : (state_q == CLEAR) ? clr_q : draw_addr;
  assign fb_wd = colour_q;
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_framebuffer_draw_engine.sv
// tb_framebuffer_draw_engine: directed self-checking bench for framebuffer_draw_engine
module tb_framebuffer_draw_engine;
  logic clk = 0, reset = 0, cmd_valid = 0, screen_on = 0;
  logic cmd_ready, fb_we, busy, done;
  logic [1:0] cmd_op = 0;
  logic [7:0] cmd_x = 0;
  logic [6:0] cmd_y = 0;
  logic [2:0] cmd_size = 0;
  logic [11:0] cmd_colour = 0, fb_wd;
  logic [14:0] disp_addr = 0, fb_addr;
  int nasserts = 0, nfail = 0, cyc;
  int wq[$];
  bit saw_ready;

  framebuffer_draw_engine dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_size(cmd_size), .cmd_colour(cmd_colour),
    .screen_on(screen_on), .disp_addr(disp_addr), .fb_addr(fb_addr), .fb_we(fb_we),
    .fb_wd(fb_wd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasserts++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input int x, input int y, input int sz, input logic [11:0] col);
    cmd_op = op;
    cmd_x = 8'(x);
    cmd_y = 7'(y);
    cmd_size = 3'(sz);
    cmd_colour = col;
    cmd_valid = 1;
    tick();
    cmd_valid = 0;
  endtask

  // records write addresses until done, cyc = cycles spent before the done cycle
  task automatic collect(input string tag, input int max);
    wq.delete();
    cyc = 0;
    saw_ready = 0;
    while (!done && cyc < max) begin
      if (fb_we) wq.push_back(int'(fb_addr));
      if (cmd_ready) saw_ready = 1;
      tick();
      cyc++;
    end
    chk({tag, " done reached"}, 32'(done), 1);
  endtask

  function automatic logic [31:0] wq_at(input int i);
    return (i < wq.size()) ? 32'(wq[i]) : 'x;
  endfunction

  initial begin
    int n, bad;
    bit seen_done;
    tick();
    tick();
    chk("rst fb_we", 32'(fb_we), 0);
    chk("rst cmd_ready", 32'(cmd_ready), 0);
    chk("rst busy", 32'(busy), 1);
    chk("rst done", 32'(done), 0);
    chk("rst fb_wd", 32'(fb_wd), 32'h0FFF);
    reset = 1;
    #1;
    n = 0;
    bad = 0;
    seen_done = 0;
    for (int c = 0; c < 19300 && !seen_done; c++) begin
      if (fb_we) begin
        if (int'(fb_addr) != n || fb_wd !== 12'hFFF) bad++;
        n++;
      end
      if (done) seen_done = 1;
      else tick();
    end
    chk("clear writes", 32'(n), 19200);
    chk("clear order/data errors", 32'(bad), 0);
    chk("clear done", 32'(seen_done), 1);
    tick();
    chk("clear then ready", 32'(cmd_ready), 1);
    chk("idle busy", 32'(busy), 0);

    issue(2'b00, 5, 3, 0, 12'h0F0);
    chk("plot we", 32'(fb_we), 1);
    chk("plot addr", 32'(fb_addr), 485);
    chk("plot data", 32'(fb_wd), 32'h0F0);
    tick();
    chk("plot done", 32'(done), 1);
    chk("plot done we", 32'(fb_we), 0);
    tick();
    chk("plot idle", 32'(cmd_ready), 1);
    chk("plot done one cycle", 32'(done), 0);

    issue(2'b01, 158, 118, 3, 12'h123);
    collect("clip", 50);
    chk("clip cycles", 32'(cyc), 9);
    chk("clip nwrites", 32'(wq.size()), 4);
    chk("clip w0", wq_at(0), 19038);
    chk("clip w1", wq_at(1), 19039);
    chk("clip w2", wq_at(2), 19198);
    chk("clip w3", wq_at(3), 19199);
    tick();

    issue(2'b01, 10, 10, 2, 12'h456);
    chk("stall first addr", 32'(fb_addr), 1610);
    chk("stall first we", 32'(fb_we), 1);
    tick();
    disp_addr = 15'h1234;
    for (int i = 0; i < 5; i++) begin
      screen_on = 1;
      #1;
      chk("stall we", 32'(fb_we), 0);
      chk("stall addr", 32'(fb_addr), 32'h1234);
      @(posedge clk);
      #1;
    end
    screen_on = 0;
    #1;
    collect("stall", 20);
    chk("stall nwrites", 32'(wq.size()), 3);
    chk("stall w1", wq_at(0), 1611);
    chk("stall w2", wq_at(1), 1770);
    chk("stall w3", wq_at(2), 1771);
    tick();

    cmd_op = 2'b01;
    cmd_x = 20;
    cmd_y = 20;
    cmd_size = 2;
    cmd_colour = 12'h00F;
    cmd_valid = 1;
    tick();
    cmd_op = 2'b00;
    cmd_x = 30;
    cmd_y = 30;
    cmd_colour = 12'hAAA;
    chk("held first data", 32'(fb_wd), 32'h00F);
    collect("held", 20);
    chk("held never ready", 32'(saw_ready), 0);
    chk("held nwrites", 32'(wq.size()), 4);
    chk("held w0", wq_at(0), 3220);
    chk("held w3", wq_at(3), 3381);
    chk("held done not ready", 32'(cmd_ready), 0);
    tick();
    chk("held idle ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 0;
    chk("held second addr", 32'(fb_addr), 4830);
    chk("held second data", 32'(fb_wd), 32'hAAA);
    collect("held2", 10);
    chk("held2 cycles", 32'(cyc), 1);
    tick();

    issue(2'b01, 50, 50, 0, 12'h777);
    collect("size0", 10);
    chk("size0 nwrites", 32'(wq.size()), 1);
    chk("size0 addr", wq_at(0), 8050);
    tick();

    issue(2'b01, 0, 0, 7, 12'h888);
    collect("size7", 40);
    chk("size7 cycles", 32'(cyc), 16);
    chk("size7 nwrites", 32'(wq.size()), 16);
    chk("size7 first", wq_at(0), 0);
    chk("size7 w4", wq_at(4), 160);
    chk("size7 last", wq_at(15), 483);
    tick();

    issue(2'b11, 0, 0, 0, 12'h000);
    chk("nop done", 32'(done), 1);
    chk("nop we", 32'(fb_we), 0);
    tick();

    issue(2'b01, 40, 40, 4, 12'h999);
    tick();
    tick();
    chk("pre-reset we", 32'(fb_we), 1);
    reset = 0;
    #1;
    chk("midreset we", 32'(fb_we), 0);
    chk("midreset busy", 32'(busy), 1);
    chk("midreset ready", 32'(cmd_ready), 0);
    chk("midreset wd", 32'(fb_wd), 32'h0FFF);
    @(posedge clk);
    #1;
    reset = 1;
    #1;
    chk("reclear we", 32'(fb_we), 1);
    chk("reclear addr0", 32'(fb_addr), 0);
    tick();
    chk("reclear addr1", 32'(fb_addr), 1);
    chk("reclear data", 32'(fb_wd), 32'h0FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
    $finish;
  end
endmodule
